match_priority_encoder: RTL
===========================

MATCH_PRIORITY_ENCODER -- requirements
Module: match_priority_encoder

Interface
REQ-001 The block SHALL have parameter D, default 512, meaning the number of TCAM match lines.
REQ-002 The block SHALL have parameter C, default 64, meaning the match lines scanned per cycle; C is a power of two and D is a multiple of C.
REQ-003 The block SHALL derive localparam SA = clog2(D) as the address width and NC = D/C as the chunk count.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: match  input  D  registered match-line vector; bit i is rule i and lower index has higher priority.
REQ-008 Port: match_valid  input  1  single-cycle qualifier for match.
REQ-009 Port: busy  output  1  high when state is not IDLE.
REQ-010 Port: result_valid  output  1  result available.
REQ-011 Port: result_ready  input  1  consumer accepts the result.
REQ-012 Port: result_hit  output  1  at least one match line was set.
REQ-013 Port: result_addr  output  SA  index of the lowest set match bit.
REQ-014 Port: result_multi  output  1  more than one match line was set.
REQ-015 Port: overrun  output  1  sticky; a match_valid was dropped.

Function
REQ-016 The FSM SHALL have the states IDLE, SCAN and DONE.
REQ-017 The block SHALL do the following in IDLE when match_valid=1: capture match into a D-bit buffer, set multi = (match & (match-1)) != 0, set chunk index k=0, and go to SCAN.
REQ-018 The block SHALL evaluate buffer bits [k*C +: C] on each SCAN edge.
REQ-019 On a SCAN edge where that chunk is nonzero, the block SHALL set result_addr = k*C + (lowest set bit position in the chunk) and result_hit=1, then go to DONE.
REQ-020 On a SCAN edge where the chunk is zero and k = NC-1, the block SHALL set result_hit=0 and result_addr=0, then go to DONE.
REQ-021 On a SCAN edge where the chunk is zero and k < NC-1, the block SHALL increment k and stay in SCAN.
REQ-022 Latency SHALL be exactly j+1 edges from the accept edge to result_valid=1, where j is the chunk index of the first hit, or NC-1 if there is no hit.
REQ-023 result_valid SHALL equal 1 exactly in DONE.
REQ-024 result_hit, result_addr and result_multi SHALL be registered and held stable throughout DONE.
REQ-025 On an edge in DONE with result_ready=1, the block SHALL go to IDLE; result_valid drops on the next cycle.
REQ-026 With result_ready=0, the block SHALL stay in DONE indefinitely.
REQ-027 A match_valid=1 in SCAN or DONE SHALL be ignored, leave the buffer unchanged, and set overrun=1.
REQ-028 overrun SHALL be cleared only by reset.
REQ-029 A match_valid that arrives on the handshake edge leaving DONE SHALL be treated as an overrun and not accepted.
REQ-030 result_ready outside DONE SHALL have no effect.
REQ-031 The result_* outputs SHALL hold their last values in IDLE and SCAN until they are overwritten on entry to DONE.
REQ-032 The chunk index k SHALL be clog2(NC) bits wide and SHALL never exceed NC-1.

Reset
REQ-033 On reset=1, the block SHALL immediately go to state=IDLE and force busy=0, result_valid=0, result_hit=0, result_addr=0, result_multi=0, overrun=0, k=0 and buffer=0.
REQ-034 Reset asserted mid-SCAN or mid-DONE SHALL abort the operation with no result produced.
REQ-035 The first edge after reset deasserts SHALL accept match_valid normally.

Verification
REQ-036 Scenario: D=512, C=64, match with only bit 0 set, match_valid pulse, result_ready=1 -> result_valid 1 edge after accept, result_hit=1, result_addr=0, result_multi=0.
REQ-037 Scenario: bits 300 and 450 set -> result_valid 5 edges after accept (chunk 4), result_addr=300, result_hit=1, result_multi=1.
REQ-038 Scenario: all-zero match -> result_valid 8 edges after accept, result_hit=0, result_addr=0, result_multi=0.
REQ-039 Scenario: bit 511 only, with result_ready=0 for 10 cycles and then 1 -> result_addr=511 held stable for all 10 cycles, then IDLE and busy=0 after the handshake edge.
REQ-040 Scenario: second match_valid during SCAN (bit 5 set, first vector had bit 200) -> result_addr=200, overrun=1 and still 1 after the next accepted operation.
REQ-041 Scenario: reset pulsed during SCAN chunk 3 -> all outputs 0 immediately and no result_valid; the next match_valid with bit 70 set gives result_addr=70 after 2 edges.

Source files
------------

// File: rtl/match_priority_encoder.sv
// Sequential lowest-index priority encoder over a D-line TCAM match vector.
// Scans C lines per cycle and holds the result until the consumer handshakes.
module match_priority_encoder #(
  parameter int unsigned D = 512,
  parameter int unsigned C = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [D-1:0]         match,
  input  logic                 match_valid,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 result_hit,
  output logic [$clog2(D)-1:0] result_addr,
  output logic                 result_multi,
  output logic                 overrun
);

  localparam int unsigned SA = $clog2(D);
  localparam int unsigned NC = D / C;
  localparam int unsigned KW = (NC > 1) ? $clog2(NC) : 1;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e        state_q, state_d;
  logic [D-1:0]  buf_q, buf_d;
  logic [KW-1:0] k_q, k_d;
  logic          hit_q, hit_d;
  logic [SA-1:0] addr_q, addr_d;
  logic          multi_q, multi_d;
  // Multi flag is computed at accept but only published on entry to DONE.
  logic          multi_pend_q, multi_pend_d;
  logic          overrun_q, overrun_d;

  logic [C-1:0]  chunk;
  logic [CW-1:0] chunk_pos;
  logic          chunk_nz;
  logic          last_chunk;

  always_comb begin
    chunk      = buf_q[32'(k_q) * C +: C];
    chunk_nz   = |chunk;
    last_chunk = (k_q == KW'(NC - 1));
    // Descending loop so the lowest set bit wins.
    chunk_pos  = '0;
    for (int i = C - 1; i >= 0; i--) begin
      if (chunk[i]) chunk_pos = CW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      buf_q        <= '0;
      k_q          <= '0;
      hit_q        <= 1'b0;
      addr_q       <= '0;
      multi_q      <= 1'b0;
      multi_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      k_q          <= k_d;
      hit_q        <= hit_d;
      addr_q       <= addr_d;
      multi_q      <= multi_d;
      multi_pend_q <= multi_pend_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    k_d          = k_q;
    hit_d        = hit_q;
    addr_d       = addr_q;
    multi_d      = multi_q;
    multi_pend_d = multi_pend_q;
    overrun_d    = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (match_valid) begin
          buf_d        = match;
          multi_pend_d = |(match & (match - D'(1)));
          k_d          = '0;
          state_d      = StScan;
        end
      end
      StScan: begin
        if (match_valid) overrun_d = 1'b1;
        if (chunk_nz) begin
          hit_d   = 1'b1;
          addr_d  = SA'(32'(k_q) * C + 32'(chunk_pos));
          multi_d = multi_pend_q;
          state_d = StDone;
        end else if (last_chunk) begin
          hit_d   = 1'b0;
          addr_d  = '0;
          multi_d = multi_pend_q;
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        // A match_valid on the leaving edge is dropped, not accepted.
        if (match_valid)  overrun_d = 1'b1;
        if (result_ready) state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q != StIdle);
    result_valid = (state_q == StDone);
    result_hit   = hit_q;
    result_addr  = addr_q;
    result_multi = multi_q;
    overrun      = overrun_q;
  end

endmodule
